vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (1-cycle read latency) between two requesters: the video fetch engine (character, attribute and char-ROM row fetches) and the CPU bus.
- Video has fixed priority. The CPU is served in idle video cycles and is guaranteed service by a starvation timer.
- Sits between video and the RAM/ROM mux in the VIC-20 top level.

Parameters:
- AW, 16, address width.
- MAX_WAIT, 8, cycles a pending CPU request may wait before it is forced ahead of video (1..255).
- ROM_LO, 16'h8000, lowest write-protected address (used with the optional feature).
- ROM_HI, 16'h8FFF, highest write-protected address (used with the optional feature).

Ports:
- clk in 1: system/pixel clock.
- reset_n in 1: asynchronous active-low reset.
- vid_req in 1: video wants a read this cycle.
- vid_addr in AW: video read address.
- vid_data out 8: read data for video.
- vid_valid out 1: vid_data valid.
- vid_miss out 1: one-cycle pulse; a video request was dropped by a forced CPU slot.
- cpu_req in 1: CPU request, held high until cpu_ack.
- cpu_we in 1: 1 = write.
- cpu_addr in AW: CPU address.
- cpu_wdata in 8: CPU write data.
- cpu_rdata out 8: CPU read data.
- cpu_ack out 1: one-cycle completion pulse.
- ram_addr out AW: RAM address (registered).
- ram_we out 1: RAM write enable (registered).
- ram_wdata out 8: RAM write data (registered).
- ram_rdata in 8: RAM read data, valid 1 cycle after ram_addr.
- wp_hit out 1: one-cycle pulse on a blocked write (optional feature only; 0 otherwise).

Behaviour:
- Reset values (async, on reset_n low): all outputs 0, state IDLE, wait counter 0, tag pipeline cleared. A CPU request in flight is abandoned and must be re-issued by the CPU after reset.
- Pipeline for every access:
  - Cycle N: decision on inputs.
  - Cycle N+1: ram_addr/ram_we/ram_wdata registered.
  - Cycle N+2: ram_rdata captured into vid_data or cpu_rdata.
  - A 2-stage owner tag (NONE/VID/CPU) travels with each slot.
- Video latency is exactly 2 cycles, vid_addr to vid_data/vid_valid, back-to-back every cycle.
- State machine:
  - IDLE:
    - cpu_req=1 and (vid_req=0 or wait counter = MAX_WAIT-1): issue the CPU slot and go to CPU_WAIT.
    - Otherwise, if vid_req=1: issue the video slot, and increment the wait counter while cpu_req=1.
  - CPU_WAIT:
    - Slot in flight; video slots may still be issued.
    - On tag CPU reaching stage 2, go to ACK.
  - ACK:
    - Reads: cpu_rdata <= ram_rdata. Writes: cpu_rdata unchanged.
    - cpu_ack=1 for this cycle only; wait counter cleared.
    - Return to IDLE. A new cpu_req is not sampled in the ACK cycle, so the CPU must drop req on ack.
- Write slot: ram_we=1 for exactly one cycle and ram_wdata=cpu_wdata. The cpu_ack for a write pulses 2 cycles after issue.
- Forced CPU slot while vid_req=1:
  - The video request is dropped and vid_miss pulses in the issue cycle.
  - vid_valid stays 0 two cycles later.
  - vid_data holds its previous value.
- Wait counter: 8-bit, saturates at MAX_WAIT-1, and is cleared whenever the CPU slot issues. MAX_WAIT=1 means the CPU always preempts video.
- At most one CPU access is outstanding. A cpu_req change while not in IDLE is ignored.
- ram_addr holds its last value in idle cycles and ram_we=0 there.

Optional Feature:
- Macro: VRAM_WP_EN.
- Defined:
  - A CPU write with ROM_LO <= cpu_addr <= ROM_HI issues a slot with ram_we=0.
  - cpu_ack still pulses at the normal time.
  - wp_hit pulses in the ack cycle.
  - Reads in the range are unaffected.
- Undefined: all writes reach RAM and wp_hit is tied 0.

Test Plan:
- Reset and video fetch: reset_n low for 3 cycles with vid_req=1 → all outputs 0 during reset. After release, with vid_req=1 and vid_addr=0x1000,0x1001,... on consecutive cycles and ram_rdata mirroring the address low byte → vid_data 0x00,0x01,... each 2 cycles after its address, with vid_valid=1 continuously.
- CPU read in an idle slot: vid_req=0, cpu_req=1, cpu_we=0, addr=0x1E00, RAM holds 0x5A → ram_addr=0x1E00 on the next cycle and cpu_ack pulses with cpu_rdata=0x5A 2 cycles after issue.
- Starvation: vid_req held 1, MAX_WAIT=8, CPU write 0x9400←0x07 → CPU slot issues on the 8th cycle, vid_miss pulses once, ram_we=1 with ram_wdata=0x07 exactly one cycle, and cpu_ack follows.
- Write protect: VRAM_WP_EN defined, write 0x8123←0xFF → ram_we stays 0, cpu_ack=1 and wp_hit=1 in the same cycle. With the macro undefined → ram_we=1 and wp_hit=0.
- Reset mid-operation: assert reset_n low one cycle after a CPU read issues → cpu_ack never pulses. After release, the re-issued request completes normally with the wait counter starting at 0.
- Simultaneous events: cpu_req and vid_req rise together with the wait counter at 0 → video is served first; the CPU completes only after vid_req drops or MAX_WAIT expires, and vid_miss is 0 in the vid_req-drop case.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has fixed priority, the CPU fills idle slots and a starvation timer forces it in.
// Optional write protection of ROM_LO..ROM_HI is enabled by defining VRAM_WP_EN.
module vram_arbiter #(
    parameter int            AW       = 16,
    parameter int            MAX_WAIT = 8,
    parameter logic [AW-1:0] ROM_LO   = 16'h8000,
    parameter logic [AW-1:0] ROM_HI   = 16'h8FFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    output logic          vid_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic          wp_hit
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

    if (MAX_WAIT < 1 || MAX_WAIT > 255 || ROM_LO > ROM_HI) begin : g_bad_param
        $error("vram_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, CPU_WAIT = 2'd1, ACK = 2'd2} state_t;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_VID = 2'd1, TAG_CPU = 2'd2} tag_t;

    state_t        state_reg, state_next;
    logic [7:0]    wait_reg, wait_next;
    logic          issue_cpu, issue_vid, wp_block;
    tag_t          tag1_reg, tag2_reg;
    logic          we1_reg;
    logic [AW-1:0] ram_addr_reg;
    logic          ram_we_reg;
    logic [7:0]    ram_wdata_reg, vid_data_reg, cpu_rdata_reg;

`ifdef VRAM_WP_EN
    assign wp_block = cpu_we && (cpu_addr >= ROM_LO) && (cpu_addr <= ROM_HI);
`else
    assign wp_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            wait_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // The CPU is only accepted from IDLE; video may be issued in every state.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        issue_cpu  = 1'b0;
        issue_vid  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (cpu_req && (!vid_req || wait_reg == WAIT_LIM)) begin
                    issue_cpu  = 1'b1;
                    wait_next  = 8'd0;
                    state_next = CPU_WAIT;
                end else if (vid_req) begin
                    issue_vid = 1'b1;
                    if (cpu_req && wait_reg != WAIT_LIM)
                        wait_next = wait_reg + 8'd1;
                end
            end
            CPU_WAIT: begin
                issue_vid = vid_req;
                if (tag1_reg == TAG_CPU)
                    state_next = ACK;
            end
            ACK: begin
                issue_vid  = vid_req;
                wait_next  = 8'd0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ram_rdata is taken in the cycle the registered address is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_reg  <= '0;
            ram_we_reg    <= 1'b0;
            ram_wdata_reg <= 8'd0;
            tag1_reg      <= TAG_NONE;
            tag2_reg      <= TAG_NONE;
            we1_reg       <= 1'b0;
            vid_data_reg  <= 8'd0;
            cpu_rdata_reg <= 8'd0;
        end else begin
            ram_we_reg <= 1'b0;
            if (issue_cpu) begin
                ram_addr_reg  <= cpu_addr;
                ram_we_reg    <= cpu_we && !wp_block;
                ram_wdata_reg <= cpu_wdata;
                tag1_reg      <= TAG_CPU;
                we1_reg       <= cpu_we;
            end else if (issue_vid) begin
                ram_addr_reg <= vid_addr;
                tag1_reg     <= TAG_VID;
            end else begin
                tag1_reg <= TAG_NONE;
            end
            tag2_reg <= tag1_reg;
            if (tag1_reg == TAG_VID)
                vid_data_reg <= ram_rdata;
            if (tag1_reg == TAG_CPU && !we1_reg)
                cpu_rdata_reg <= ram_rdata;
        end
    end

`ifdef VRAM_WP_EN
    logic wp1_reg, wp_hit_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp1_reg    <= 1'b0;
            wp_hit_reg <= 1'b0;
        end else begin
            wp1_reg    <= issue_cpu && wp_block;
            wp_hit_reg <= (tag1_reg == TAG_CPU) && wp1_reg;
        end
    end

    assign wp_hit = wp_hit_reg;
`else
    assign wp_hit = 1'b0;
`endif

    assign ram_addr  = ram_addr_reg;
    assign ram_we    = ram_we_reg;
    assign ram_wdata = ram_wdata_reg;
    assign vid_data  = vid_data_reg;
    assign vid_valid = (tag2_reg == TAG_VID);
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_ack   = (state_reg == ACK);
    assign vid_miss  = reset_n && issue_cpu && vid_req;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic checked against a slot-level reference model.
module tb_vram_arbiter;

    localparam int AW       = 16;
    localparam int MAX_WAIT = 8;
    localparam int K_NONE   = 0;
    localparam int K_VID    = 1;
    localparam int K_CPU    = 2;

    logic          clk, reset_n;
    logic          vid_req, vid_valid, vid_miss;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we, wp_hit;
    logic [7:0]    ram_wdata, ram_rdata;

    vram_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .wp_hit(wp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench RAM: data follows the presented address, writes commit on the clock edge.
    logic [7:0] ram [0:65535];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    // Reference model: one slot per cycle, each slot's effects land a fixed number of cycles later.
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        wp;
        logic [7:0]  data;
    } slot_t;

    logic [7:0]  mm [0:65535];
    slot_t       s0, s1, s2;
    int          cyc, last_cpu, waited;
    logic [7:0]  e_vdata, e_cdata;
    logic [15:0] e_raddr;
    logic        cpu_pending;
    int          n_checks, n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic is_wp(input logic we, input logic [15:0] a);
`ifdef VRAM_WP_EN
        return we && a >= 16'h8000 && a <= 16'h8FFF;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        s0 = '0; s1 = '0; s2 = '0;
        waited = 0; last_cpu = -100;
        e_vdata = 8'h00; e_cdata = 8'h00; e_raddr = 16'h0000;
    endtask

    task automatic check_outputs();
        cyc++;
        s2 = s1; s1 = s0; s0 = '0;
        if (s1.kind == 2'(K_CPU) && s1.we) begin
            if (!s1.wp) mm[s1.addr] = s1.wdata;
        end else if (s1.kind != 2'(K_NONE)) begin
            s1.data = mm[s1.addr];
        end
        if (s1.kind != 2'(K_NONE)) e_raddr = s1.addr;
        if (s2.kind == 2'(K_VID)) e_vdata = s2.data;
        if (s2.kind == 2'(K_CPU) && !s2.we) e_cdata = s2.data;
        if (s2.kind == 2'(K_CPU))
            $display("cpu %s addr=%h wdata=%h rdata=%h wp=%b (cycle %0d)",
                     s2.we ? "wr" : "rd", s2.addr, s2.wdata, cpu_rdata, wp_hit, cyc);
        check_eq("vid_valid", 32'(vid_valid), 32'(s2.kind == 2'(K_VID)));
        check_eq("vid_data",  32'(vid_data),  32'(e_vdata));
        check_eq("cpu_ack",   32'(cpu_ack),   32'(s2.kind == 2'(K_CPU)));
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(e_cdata));
        check_eq("wp_hit",    32'(wp_hit),    32'(s2.kind == 2'(K_CPU) && s2.wp));
        check_eq("ram_addr",  32'(ram_addr),  32'(e_raddr));
        check_eq("ram_we",    32'(ram_we),    32'(s1.kind == 2'(K_CPU) && s1.we && !s1.wp));
        if (s1.kind == 2'(K_CPU) && s1.we && !s1.wp)
            check_eq("ram_wdata", 32'(ram_wdata), 32'(s1.wdata));
    endtask

    task automatic drive_decide(input logic v_req, input logic [15:0] v_addr,
                                input logic c_start, input logic c_we,
                                input logic [15:0] c_addr, input logic [7:0] c_data);
        logic free, go;
        if (cpu_pending && cpu_ack) begin
            cpu_req = 1'b0; cpu_pending = 1'b0;
        end else if (!cpu_pending && c_start) begin
            cpu_req = 1'b1; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_data;
            cpu_pending = 1'b1;
        end
        vid_req = v_req; vid_addr = v_addr;
        free = (cyc > last_cpu + 2);
        go = free && cpu_req && (!vid_req || waited >= MAX_WAIT - 1);
        if (go) begin
            s0 = '{kind: 2'(K_CPU), addr: cpu_addr, we: cpu_we, wdata: cpu_wdata,
                   wp: is_wp(cpu_we, cpu_addr), data: 8'h00};
            last_cpu = cyc; waited = 0;
        end else begin
            if (vid_req) s0 = '{kind: 2'(K_VID), addr: vid_addr, we: 1'b0, wdata: 8'h00, wp: 1'b0, data: 8'h00};
            if (free && cpu_req && vid_req && waited < MAX_WAIT - 1) waited++;
        end
        #1;
        check_eq("vid_miss", 32'(vid_miss), 32'(go && vid_req));
    endtask

    task automatic tick(input logic v_req, input logic [15:0] v_addr,
                        input logic c_start, input logic c_we,
                        input logic [15:0] c_addr, input logic [7:0] c_data);
        @(posedge clk); #1;
        check_outputs();
        drive_decide(v_req, v_addr, c_start, c_we, c_addr, c_data);
    endtask

    task automatic idle_ticks(input int n, input logic v_req);
        for (int i = 0; i < n; i++) tick(v_req, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_pending = 1'b0;
        vid_req = 1'b1; vid_addr = 16'h1000;
        model_clear();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            #1;
            check_eq("rst_outputs",
                     {vid_data, cpu_rdata, ram_wdata, 3'b0, vid_valid, vid_miss, cpu_ack, ram_we, wp_hit},
                     32'h0);
            check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive_decide(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rbase [0:4];
        logic [15:0] ca;
        n_checks = 0; n_errors = 0; cyc = 0; cpu_pending = 1'b0;
        reset_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int a = 0; a < 65536; a++) begin
            ram[a] = 8'(a);
            mm[a]  = 8'(a);
        end
        ram[16'h1E00] = 8'h5A; mm[16'h1E00] = 8'h5A;
        model_clear();

        do_reset(3);
        for (int i = 0; i < 12; i++) tick(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 8'h0);

        tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h1E00, 8'h00);
        idle_ticks(4, 1'b0);

        tick(1'b1, 16'h1100, 1'b1, 1'b1, 16'h9400, 8'h07);
        idle_ticks(13, 1'b1);

        tick(1'b0, 16'h0, 1'b1, 1'b1, 16'h8123, 8'hFF);
        idle_ticks(4, 1'b0);

        tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h1E01, 8'h00);
        do_reset(2);
        tick(1'b1, 16'h1200, 1'b1, 1'b0, 16'h1E01, 8'h00);
        idle_ticks(12, 1'b1);

        idle_ticks(2, 1'b0);
        tick(1'b1, 16'h1300, 1'b1, 1'b0, 16'h9400, 8'h00);
        idle_ticks(2, 1'b1);
        idle_ticks(4, 1'b0);

        rbase[0] = 16'h7FFE; rbase[1] = 16'h8000; rbase[2] = 16'h8FFE;
        rbase[3] = 16'h9000; rbase[4] = 16'h1E00;
        for (int i = 0; i < 1500; i++) begin
            ca = rbase[$urandom_range(0, 4)] + 16'($urandom_range(0, 2));
            tick($urandom_range(0, 9) < 7,
                 ($urandom_range(0, 1) == 0) ? ca : 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), ca, 8'($urandom_range(0, 255)));
        end
        idle_ticks(4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
